// File: rtl/hazard_ctrl.sv
// hazard_ctrl
//   Pipeline hazard controller. It stalls the front end for one cycle on a
//   load-use dependency and squashes the wrong-path instructions when EX
//   resolves a branch or jump as taken. Two saturating 16-bit counters record
//   how often each event occurs.
//
// Ports
//   clk             in   rising-edge clock
//   reset_n         in   asynchronous active-low reset
//   ID_ReadRegNum1  in   [4:0] rs1 of the instruction in ID
//   ID_ReadRegNum2  in   [4:0] rs2 of the instruction in ID
//   ID_UsesRs1      in   ID instruction reads rs1
//   ID_UsesRs2      in   ID instruction reads rs2
//   EX_cntl_MemRead in   instruction in EX is a load
//   EX_WriteRegNum  in   [4:0] destination register of the instruction in EX
//   EX_BranchTaken  in   branch/jump in EX resolved taken
//   cnt_clr         in   synchronous clear of both counters (wins over increment)
//   PCWrite         out  PC write enable
//   IF_IDWrite      out  IF/ID register write enable
//   IF_IDFlush      out  turn IF/ID into a bubble
//   ID_EXFlush      out  turn ID/EX into a bubble
//   hz_state        out  [1:0] current FSM state (debug)
//   lu_stall_cnt    out  [15:0] number of load-use stalls taken (saturating)
//   br_flush_cnt    out  [15:0] number of taken-branch flushes (saturating)
//
// Handshake: none. All control outputs are combinational in the current state
// and the current-cycle inputs; they take effect on the next rising clk.
module hazard_ctrl (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [4:0]  ID_ReadRegNum1,
  input  logic [4:0]  ID_ReadRegNum2,
  input  logic        ID_UsesRs1,
  input  logic        ID_UsesRs2,
  input  logic        EX_cntl_MemRead,
  input  logic [4:0]  EX_WriteRegNum,
  input  logic        EX_BranchTaken,
  input  logic        cnt_clr,
  output logic        PCWrite,
  output logic        IF_IDWrite,
  output logic        IF_IDFlush,
  output logic        ID_EXFlush,
  output logic [1:0]  hz_state,
  output logic [15:0] lu_stall_cnt,
  output logic [15:0] br_flush_cnt
);

  localparam logic [1:0] ST_RUN       = 2'b00;
  localparam logic [1:0] ST_LU_STALL  = 2'b01;
  localparam logic [1:0] ST_BR_SHADOW = 2'b10;

  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  logic [1:0]  r_state;
  logic [1:0]  w_state_next;
  logic [15:0] r_lu_stall_cnt;
  logic [15:0] r_br_flush_cnt;

  logic w_lu_hazard;
  logic w_pc_write;
  logic w_if_id_write;
  logic w_if_id_flush;
  logic w_id_ex_flush;
  logic w_enter_lu_stall;

  // x0 is hard-wired zero, so a load targeting it never creates a dependency.
  assign w_lu_hazard = EX_cntl_MemRead && (EX_WriteRegNum != 5'd0) &&
                       ((ID_UsesRs1 && (ID_ReadRegNum1 == EX_WriteRegNum)) ||
                        (ID_UsesRs2 && (ID_ReadRegNum2 == EX_WriteRegNum)));

  always_comb begin
    w_state_next  = ST_RUN;
    w_pc_write    = 1'b1;
    w_if_id_write = 1'b1;
    w_if_id_flush = 1'b0;
    w_id_ex_flush = 1'b0;
    if (EX_BranchTaken) begin
      // Taken branch wins in every state: fetch the target, squash both
      // wrong-path slots. The IF/ID flush is only meaningful while IF/ID is
      // being written, which is always true here.
      w_if_id_flush = 1'b1;
      w_id_ex_flush = 1'b1;
      w_state_next  = ST_BR_SHADOW;
    end else if ((r_state == ST_RUN) && w_lu_hazard) begin
      // Hold PC and IF/ID, send a bubble into EX.
      w_pc_write    = 1'b0;
      w_if_id_write = 1'b0;
      w_id_ex_flush = 1'b1;
      w_state_next  = ST_LU_STALL;
    end
    // LU_STALL and BR_SHADOW without a branch ignore the hazard: the load has
    // moved on to MEM, so the dependent instruction needs only one bubble.
  end

  assign w_enter_lu_stall = (w_state_next == ST_LU_STALL);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_lu_stall_cnt <= 16'd0;
      r_br_flush_cnt <= 16'd0;
    end else if (cnt_clr) begin
      r_lu_stall_cnt <= 16'd0;
      r_br_flush_cnt <= 16'd0;
    end else begin
      if (w_enter_lu_stall && (r_lu_stall_cnt != CNT_MAX)) begin
        r_lu_stall_cnt <= r_lu_stall_cnt + 16'd1;
      end
      if (EX_BranchTaken && (r_br_flush_cnt != CNT_MAX)) begin
        r_br_flush_cnt <= r_br_flush_cnt + 16'd1;
      end
    end
  end

  // While reset is held the pipeline must free-run with no bubbles, even if
  // the EX inputs happen to show a taken branch.
  assign PCWrite      = w_pc_write    || !reset_n;
  assign IF_IDWrite   = w_if_id_write || !reset_n;
  assign IF_IDFlush   = w_if_id_flush && reset_n;
  assign ID_EXFlush   = w_id_ex_flush && reset_n;
  assign hz_state     = r_state;
  assign lu_stall_cnt = r_lu_stall_cnt;
  assign br_flush_cnt = r_br_flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl
//   Directed bench for hazard_ctrl. A reference model tracks only "what
//   happened last cycle" (nothing, a stall, or a taken branch) plus two
//   integer counters, and derives the expected outputs from the hazard rules.
//   Every cycle the outputs are compared with the model at the falling edge;
//   literal expectations pin the model at the key scenarios.
`timescale 1ns/1ps
module tb_hazard_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic [4:0]  rs1, rs2, ex_wr;
  logic        use1, use2, mem_rd, br, clr;
  logic        pc_we, ifid_we, ifid_fl, idex_fl;
  logic [1:0]  st;
  logic [15:0] lu_cnt, br_cnt;

  hazard_ctrl dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .ID_ReadRegNum1 (rs1),
    .ID_ReadRegNum2 (rs2),
    .ID_UsesRs1     (use1),
    .ID_UsesRs2     (use2),
    .EX_cntl_MemRead(mem_rd),
    .EX_WriteRegNum (ex_wr),
    .EX_BranchTaken (br),
    .cnt_clr        (clr),
    .PCWrite        (pc_we),
    .IF_IDWrite     (ifid_we),
    .IF_IDFlush     (ifid_fl),
    .ID_EXFlush     (idex_fl),
    .hz_state       (st),
    .lu_stall_cnt   (lu_cnt),
    .br_flush_cnt   (br_cnt)
  );

  // ---------------- model ----------------
  // m_last: 0 = previous cycle was ordinary, 1 = it took a load-use stall,
  // 2 = it saw a taken branch. This is also what hz_state must show.
  int n_checks = 0;
  int n_fail   = 0;
  int m_last   = 0;
  int m_lu     = 0;
  int m_br     = 0;

  function automatic bit model_hazard();
    return mem_rd && (ex_wr != 0) &&
           ((use1 && rs1 == ex_wr) || (use2 && rs2 == ex_wr));
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every output against the model.
  task automatic settle();
    bit e_pc, e_ifw, e_iff, e_exf;
    @(negedge clk);
    if (!reset_n) begin
      e_pc = 1; e_ifw = 1; e_iff = 0; e_exf = 0;
    end else if (br) begin
      e_pc = 1; e_ifw = 1; e_iff = 1; e_exf = 1;
    end else if (m_last == 0 && model_hazard()) begin
      e_pc = 0; e_ifw = 0; e_iff = 0; e_exf = 1;
    end else begin
      e_pc = 1; e_ifw = 1; e_iff = 0; e_exf = 0;
    end
    check("PCWrite",      32'(pc_we),   32'(e_pc));
    check("IF_IDWrite",   32'(ifid_we), 32'(e_ifw));
    check("IF_IDFlush",   32'(ifid_fl), 32'(e_iff));
    check("ID_EXFlush",   32'(idex_fl), 32'(e_exf));
    check("flush_w_hold", 32'(ifid_fl && !ifid_we), 32'd0);
    check("hz_state",     32'(st),      reset_n ? 32'(m_last) : 32'd0);
    check("lu_stall_cnt", 32'(lu_cnt),  32'(m_lu));
    check("br_flush_cnt", 32'(br_cnt),  32'(m_br));
  endtask

  // Clock edge: update the model with the inputs that the edge samples.
  task automatic advance();
    bit enter;
    @(posedge clk);
    if (!reset_n) begin
      m_last = 0; m_lu = 0; m_br = 0;
    end else begin
      enter = !br && (m_last == 0) && model_hazard();
      if (clr) begin
        m_lu = 0; m_br = 0;
      end else begin
        if (enter) m_lu = (m_lu >= 65535) ? 65535 : m_lu + 1;
        if (br)    m_br = (m_br >= 65535) ? 65535 : m_br + 1;
      end
      m_last = br ? 2 : (enter ? 1 : 0);
    end
    #1;
  endtask

  // ---------------- driver ----------------
  task automatic drive(input bit b, input bit mr, input logic [4:0] wr,
                       input logic [4:0] r1, input logic [4:0] r2,
                       input bit u1, input bit u2, input bit c);
    br = b; mem_rd = mr; ex_wr = wr; rs1 = r1; rs2 = r2;
    use1 = u1; use2 = u2; clr = c;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic load_use();
    drive(0, 1, 5'd5, 5'd5, 5'd1, 1, 1, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset_n = 1'b0;
    drive(1, 1, 5'd5, 5'd5, 5'd0, 1, 0, 0);  // branch + hazard while in reset
    #2;
    check("rst_PCWrite",    32'(pc_we),   32'd1);
    check("rst_IF_IDFlush", 32'(ifid_fl), 32'd0);
    check("rst_ID_EXFlush", 32'(idex_fl), 32'd0);
    check("rst_hz_state",   32'(st),      32'd0);
    settle(); advance();
    settle(); advance();
    reset_n = 1'b1;
    idle();
    settle(); advance();

    // Load-use on rs1.
    load_use();
    settle();
    check("lu_PCWrite",    32'(pc_we),   32'd0);
    check("lu_IF_IDWrite", 32'(ifid_we), 32'd0);
    check("lu_ID_EXFlush", 32'(idex_fl), 32'd1);
    advance();
    settle();  // hazard still present, stall not repeated
    check("lu2_hz_state", 32'(st),      32'd1);
    check("lu2_PCWrite",  32'(pc_we),   32'd1);
    check("lu2_ID_EXFl",  32'(idex_fl), 32'd0);
    check("lu2_cnt",      32'(lu_cnt),  32'd1);
    advance();
    idle(); settle(); advance();

    // x0 never hazardous; unused rs2 never hazardous.
    drive(0, 1, 5'd0, 5'd0, 5'd0, 1, 1, 0);
    settle();
    check("x0_PCWrite", 32'(pc_we), 32'd1);
    advance();
    drive(0, 1, 5'd7, 5'd3, 5'd7, 1, 0, 0);
    settle();
    check("rs2unused_PCWrite", 32'(pc_we), 32'd1);
    advance();
    settle();
    check("nostall_hz_state", 32'(st), 32'd0);
    advance();

    // Branch together with a load-use hazard in RUN.
    drive(1, 1, 5'd9, 5'd9, 5'd0, 1, 0, 0);
    settle();
    check("sim_IF_IDFlush", 32'(ifid_fl), 32'd1);
    check("sim_ID_EXFlush", 32'(idex_fl), 32'd1);
    check("sim_PCWrite",    32'(pc_we),   32'd1);
    advance();
    idle(); settle();
    check("sim_hz_state", 32'(st),     32'd2);
    check("sim_lu_cnt",   32'(lu_cnt), 32'd1);
    check("sim_br_cnt",   32'(br_cnt), 32'd1);
    advance();

    // Clear, then back-to-back branches.
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    settle(); advance();
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    settle(); check("bb1_IF_IDFlush", 32'(ifid_fl), 32'd1); advance();
    settle(); check("bb2_IF_IDFlush", 32'(ifid_fl), 32'd1);
    check("bb2_hz_state", 32'(st), 32'd2);
    advance();
    idle(); settle();
    check("bb_hz_state", 32'(st),     32'd2);
    check("bb_br_cnt",   32'(br_cnt), 32'd2);
    check("bb_lu_cnt",   32'(lu_cnt), 32'd0);
    advance();

    // Hazard in BR_SHADOW is ignored.
    drive(1, 0, 0, 0, 0, 0, 0, 0); settle(); advance();
    load_use(); settle();
    check("shadow_PCWrite", 32'(pc_we), 32'd1);
    advance();

    // Mixed directed/random traffic on a small register range.
    for (int i = 0; i < 300; i++) begin
      drive($urandom_range(0, 5) == 0, $urandom_range(0, 1) == 1,
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), $urandom_range(0, 1) == 1,
            $urandom_range(0, 1) == 1, $urandom_range(0, 40) == 0);
      settle(); advance();
    end
    idle(); settle(); advance();

    // Saturation: preload near the top, then stall past it.
    force dut.r_lu_stall_cnt = 16'hFFFD;
    #1;
    release dut.r_lu_stall_cnt;
    m_lu = 16'hFFFD;
    for (int i = 0; i < 4; i++) begin
      load_use(); settle(); advance();
      idle();     settle(); advance();
    end
    settle();
    check("sat_lu_cnt", 32'(lu_cnt), 32'hFFFF);
    advance();
    // Clear with a coincident stall.
    drive(0, 1, 5'd5, 5'd5, 5'd1, 1, 1, 1);
    settle(); advance();
    idle(); settle();
    check("clr_lu_cnt", 32'(lu_cnt), 32'd0);
    advance();

    // Reset asserted mid-stall, no clock edge needed.
    drive(1, 0, 0, 0, 0, 0, 0, 0); settle(); advance();
    idle(); settle(); advance();
    load_use(); settle(); advance();
    #1;
    reset_n = 1'b0;
    #1;
    check("rstmid_hz_state", 32'(st),     32'd0);
    check("rstmid_lu_cnt",   32'(lu_cnt), 32'd0);
    check("rstmid_br_cnt",   32'(br_cnt), 32'd0);
    check("rstmid_PCWrite",  32'(pc_we),  32'd1);
    m_last = 0; m_lu = 0; m_br = 0;
    settle(); advance();
    reset_n = 1'b1;
    load_use(); settle();
    check("post_rst_PCWrite", 32'(pc_we), 32'd0);
    advance();
    idle(); settle();
    check("post_rst_lu_cnt", 32'(lu_cnt), 32'd1);
    advance();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
